// File: rtl/bus_invert_rx.sv
`default_nettype none
// ============================================================================
// Module      : bus_invert_rx
// Description : Receive end of a bus-invert coded link. Decodes the encoded
//               bus (bus_data ^ {WIDTH{bus_inv}}) into a 2-entry registered
//               FIFO with valid/ready handshakes on both sides. It also checks
//               every accepted word against the bus-invert rule: the Hamming
//               distance on the data lines must be no more than WIDTH/2. A
//               violation sets a sticky error flag.
// Optional    : BI_RX_ACTIVITY_EN adds toggle-activity counters. These are
//               the tog_bus and tog_raw outputs, the cnt_clr input and the
//               CNT_W parameter.
// Ports       : clk, rst_n           - clock, async active-low reset
//               bus_data/bus_inv     - encoded word and its invert line
//               bus_valid/bus_ready  - input handshake (ready = FIFO not full)
//               dout/dout_valid      - head of FIFO, FIFO not empty
//               dout_ready           - consumer accepts dout
//               bi_err/err_clr       - sticky rule violation, sync clear
//               tog_bus/tog_raw      - encoded / un-encoded toggle counts
//               cnt_clr              - sync clear of both counters
// Revision    : 1.0 - initial release
// ============================================================================
module bus_invert_rx #(
    parameter int WIDTH = 8
`ifdef BI_RX_ACTIVITY_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus_data,
    input  logic             bus_inv,
    input  logic             bus_valid,
    output logic             bus_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             bi_err,
    input  logic             err_clr
`ifdef BI_RX_ACTIVITY_EN
    ,
    output logic [CNT_W-1:0] tog_bus,
    output logic [CNT_W-1:0] tog_raw,
    input  logic             cnt_clr
`endif
);

    // Popcount width. It covers up to WIDTH+1 set bits, because the bus
    // toggle count includes the invert line.
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] c_half = CW'(WIDTH / 2);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_t;

    fifo_state_t r_state;
    fifo_state_t w_state_nxt;

    logic [WIDTH-1:0] r_mem [0:1];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [WIDTH-1:0] r_prev_bus;

    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_raw;
    logic [CW-1:0]    w_dist;
    logic             w_viol;

    function automatic logic [CW-1:0] popcount(input logic [WIDTH:0] v);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            cnt = cnt + {{(CW-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // ------------------------------------------------------------------
    // Handshake and decode
    // ------------------------------------------------------------------
    // Ready depends only on occupancy. A pop while full frees the slot for
    // the following cycle, so there is no path from dout_ready to bus_ready.
    assign bus_ready  = (r_state != ST_FULL);
    assign dout_valid = (r_state != ST_EMPTY);
    assign w_push     = bus_valid & bus_ready;
    assign w_pop      = dout_valid & dout_ready;
    assign w_raw      = bus_data ^ {WIDTH{bus_inv}};
    assign dout       = r_mem[r_rd_ptr];

    // The rule is checked on the data lines only. The invert line is excluded.
    assign w_dist = popcount({1'b0, bus_data ^ r_prev_bus});
    assign w_viol = (w_dist > c_half);

    // ------------------------------------------------------------------
    // FIFO occupancy FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_EMPTY: if (w_push)           w_state_nxt = ST_ONE;
            ST_ONE: begin
                if (w_push && !w_pop)       w_state_nxt = ST_FULL;
                else if (w_pop && !w_push)  w_state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (w_pop)            w_state_nxt = ST_ONE;
            default:                        w_state_nxt = ST_EMPTY;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO storage. The entries are cleared on reset so that dout reads 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_raw;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Rule checker. History advances only on accepted words, so idle and
    // stalled cycles do not count as transitions.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_bus <= '0;
            bi_err     <= 1'b0;
        end else begin
            if (w_push) begin
                r_prev_bus <= bus_data;
            end
            // A new violation wins over a clear in the same cycle.
            if (w_push && w_viol) begin
                bi_err <= 1'b1;
            end else if (err_clr) begin
                bi_err <= 1'b0;
            end
        end
    end

`ifdef BI_RX_ACTIVITY_EN
    // ------------------------------------------------------------------
    // Activity counters (saturating)
    // ------------------------------------------------------------------
    localparam int SUM_W = ((CNT_W > CW) ? CNT_W : CW) + 1;
    localparam logic [SUM_W-1:0] c_cnt_max = SUM_W'({CNT_W{1'b1}});

    logic             r_prev_inv;
    logic [WIDTH-1:0] r_prev_raw;
    logic [CW-1:0]    w_inc_bus;
    logic [CW-1:0]    w_inc_raw;
    logic [SUM_W-1:0] w_sum_bus;
    logic [SUM_W-1:0] w_sum_raw;

    assign w_inc_bus = popcount({bus_inv, bus_data} ^ {r_prev_inv, r_prev_bus});
    assign w_inc_raw = popcount({1'b0, w_raw ^ r_prev_raw});
    // The sum is one bit wider than either operand, so it cannot wrap
    // before it is compared with the saturation limit.
    assign w_sum_bus = SUM_W'(tog_bus) + SUM_W'(w_inc_bus);
    assign w_sum_raw = SUM_W'(tog_raw) + SUM_W'(w_inc_raw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_inv <= 1'b0;
            r_prev_raw <= '0;
            tog_bus    <= '0;
            tog_raw    <= '0;
        end else begin
            if (w_push) begin
                r_prev_inv <= bus_inv;
                r_prev_raw <= w_raw;
            end
            // The clear takes precedence. A coinciding push's increment is lost.
            if (cnt_clr) begin
                tog_bus <= '0;
                tog_raw <= '0;
            end else if (w_push) begin
                tog_bus <= (w_sum_bus > c_cnt_max) ? {CNT_W{1'b1}} : w_sum_bus[CNT_W-1:0];
                tog_raw <= (w_sum_raw > c_cnt_max) ? {CNT_W{1'b1}} : w_sum_raw[CNT_W-1:0];
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_invert_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_invert_rx
// Description : Directed, self-checking bench for bus_invert_rx at WIDTH=8.
//               With BI_RX_ACTIVITY_EN defined, it also exercises the activity
//               counters, using CNT_W=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_invert_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] bus_data;
    logic         bus_inv;
    logic         bus_valid;
    logic         bus_ready;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         bi_err;
    logic         err_clr;
`ifdef BI_RX_ACTIVITY_EN
    logic [3:0]   tog_bus;
    logic [3:0]   tog_raw;
    logic         cnt_clr;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef BI_RX_ACTIVITY_EN
    bus_invert_rx #(.WIDTH(W), .CNT_W(4)) dut (
`else
    bus_invert_rx #(.WIDTH(W)) dut (
`endif
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_data   (bus_data),
        .bus_inv    (bus_inv),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .bi_err     (bi_err),
        .err_clr    (err_clr)
`ifdef BI_RX_ACTIVITY_EN
        ,
        .tog_bus    (tog_bus),
        .tog_raw    (tog_raw),
        .cnt_clr    (cnt_clr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic inv, input logic [W-1:0] d);
        bus_valid = v;
        bus_inv   = inv;
        bus_data  = d;
    endtask

    initial begin
        rst_n      = 1'b0;
        dout_ready = 1'b0;
        err_clr    = 1'b0;
`ifdef BI_RX_ACTIVITY_EN
        cnt_clr    = 1'b0;
`endif
        drive(1'b0, 1'b0, 8'h00);
        repeat (3) step();

        // Reset state
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_bus_ready",  32'(bus_ready),  32'd1);
        chk("rst_bi_err",     32'(bi_err),     32'd0);
        chk("rst_dout",       32'(dout),       32'h00);
        rst_n = 1'b1;

        // Decode: inverted word, then a plain word with push+pop at count 1
        drive(1'b1, 1'b1, 8'h0F);
        step();
        chk("dec_inv_dout",  32'(dout),       32'hF0);
        chk("dec_inv_valid", 32'(dout_valid), 32'd1);
        drive(1'b1, 1'b0, 8'h0F);
        dout_ready = 1'b1;
        step();
        chk("dec_plain_dout", 32'(dout),       32'h0F);
        chk("pp_cnt1_valid",  32'(dout_valid), 32'd1);
        chk("pp_cnt1_ready",  32'(bus_ready),  32'd1);
        chk("dec_bi_err",     32'(bi_err),     32'd0);
        drive(1'b0, 1'b0, 8'h00);
        step();
        chk("drain_valid", 32'(dout_valid), 32'd0);
        dout_ready = 1'b0;

        // Backpressure (prev_bus = 0F)
        drive(1'b1, 1'b0, 8'h0E);
        step();
        chk("bp_ready_1", 32'(bus_ready), 32'd1);
        drive(1'b1, 1'b0, 8'h0C);
        step();
        chk("bp_ready_2", 32'(bus_ready), 32'd0);
        drive(1'b1, 1'b0, 8'h08);
        step();
        chk("bp_ready_hold", 32'(bus_ready), 32'd0);
        chk("bp_dout_hold",  32'(dout),      32'h0E);
        drive(1'b0, 1'b0, 8'h00);
        dout_ready = 1'b1;
        step();
        chk("bp_pop1_dout",  32'(dout),      32'h0C);
        chk("bp_pop1_ready", 32'(bus_ready), 32'd1);
        step();
        chk("bp_pop2_valid", 32'(dout_valid), 32'd0);

        // Rule violation (prev_bus = 0C; the third word was never taken)
        drive(1'b1, 1'b0, 8'h00);        // d=2
        step();
        chk("rv_base_err", 32'(bi_err), 32'd0);
        drive(1'b1, 1'b0, 8'h1F);        // d=5
        step();
        chk("rv_set_err",  32'(bi_err), 32'd1);
        chk("rv_set_dout", 32'(dout),   32'h1F);
        drive(1'b1, 1'b0, 8'h00);        // d=5 again, with clear
        err_clr = 1'b1;
        step();
        chk("rv_clr_vs_set", 32'(bi_err), 32'd1);
        drive(1'b0, 1'b0, 8'h00);
        step();
        chk("rv_clr_alone", 32'(bi_err), 32'd0);
        err_clr    = 1'b0;
        dout_ready = 1'b0;

        // Boundary: d = W/2 is legal; the invert line is excluded from d
        drive(1'b1, 1'b0, 8'h0F);        // d=4 from 00
        step();
        chk("bd_d4_err",  32'(bi_err), 32'd0);
        chk("bd_d4_dout", 32'(dout),   32'h0F);
        drive(1'b1, 1'b1, 8'h0F);        // d=0, raw=F0
        step();
        chk("bd_inv_err",   32'(bi_err),    32'd0);
        chk("bd_full_rdy",  32'(bus_ready), 32'd0);
        drive(1'b0, 1'b0, 8'h00);
        dout_ready = 1'b1;
        step();
        chk("bd_second_dout", 32'(dout), 32'hF0);
        step();
        chk("bd_empty", 32'(dout_valid), 32'd0);
        dout_ready = 1'b0;

        // Asynchronous reset mid-traffic
        drive(1'b1, 1'b0, 8'hF0);        // d=8 from 0F
        step();
        chk("mt_err_set", 32'(bi_err),     32'd1);
        chk("mt_valid",   32'(dout_valid), 32'd1);
        drive(1'b0, 1'b0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_dout_valid", 32'(dout_valid), 32'd0);
        chk("ar_bus_ready",  32'(bus_ready),  32'd1);
        chk("ar_bi_err",     32'(bi_err),     32'd0);
        chk("ar_dout",       32'(dout),       32'h00);
`ifdef BI_RX_ACTIVITY_EN
        chk("ar_tog_bus",    32'(tog_bus),    32'd0);
        chk("ar_tog_raw",    32'(tog_raw),    32'd0);
`endif
        step();
        rst_n = 1'b1;

`ifdef BI_RX_ACTIVITY_EN
        // Counters from reset (all prev = 0), CNT_W = 4
        dout_ready = 1'b1;
        drive(1'b1, 1'b1, 8'hFF);        // bus +9, raw 00 -> +0
        step();
        chk("ac_bus_1", 32'(tog_bus), 32'd9);
        chk("ac_raw_1", 32'(tog_raw), 32'd0);
        drive(1'b1, 1'b0, 8'hFF);        // bus +1, raw FF -> +8
        step();
        chk("ac_bus_2", 32'(tog_bus), 32'd10);
        chk("ac_raw_2", 32'(tog_raw), 32'd8);
        drive(1'b1, 1'b1, 8'hFF);        // bus +1, raw +8 -> saturate
        step();
        chk("ac_bus_3", 32'(tog_bus), 32'd11);
        chk("ac_raw_sat", 32'(tog_raw), 32'd15);
        drive(1'b1, 1'b0, 8'hFF);
        step();
        chk("ac_raw_hold", 32'(tog_raw), 32'd15);
        drive(1'b1, 1'b1, 8'hFF);
        cnt_clr = 1'b1;
        step();
        chk("ac_clr_bus", 32'(tog_bus), 32'd0);
        chk("ac_clr_raw", 32'(tog_raw), 32'd0);
        cnt_clr = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
